delay_sched: RTL and testbench

Sequencer for a bank of NUM_UNITS delay-line units. It holds the per-unit delay amounts and drives the shared run strobe. It generates input-feed and output-valid windows so downstream logic only samples aligned data once every delay line is primed. It sits between the accelerator configuration bus and the delay units' amount/run inputs.

---
 rtl/delay_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_delay_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sched.sv
// ---------------------------------------------------------------------------
// delay_sched
//
// Sequencer for a bank of NUM_UNITS delay-line units. It keeps a shadow copy
// of every unit's delay amount, which the configuration bus writes. It
// copies the shadows into the active amount register when a stream starts,
// and drives the shared run strobe for the stream. It also produces an
// input-feed window (in_valid) and an output window (out_valid). The output
// window only opens once the deepest delay line has been primed.
//
// Optional feature:
//   DELAY_SCHED_CLAMP_EN - when defined, amount writes above 2^ADDRESS_WIDTH-2
//                          are clamped to 2^ADDRESS_WIDTH-2 and do not raise
//                          cfg_err. When undefined, such a write stores the
//                          value unmodified and raises cfg_err.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   cfg_we     in   write the shadow amount selected by cfg_addr
//   cfg_addr   in   shadow register index (out-of-range writes are ignored)
//   cfg_amount in   amount value to write
//   start      in   start a stream (only honoured while idle)
//   len        in   stream length in samples, captured with start
//   busy       out  high from the cycle after an accepted start through done
//   done       out  one-cycle end-of-stream pulse
//   run        out  run strobe to all delay units
//   in_valid   out  upstream may present a sample this cycle
//   out_valid  out  delay outputs carry aligned data this cycle
//   amount     out  active amounts, unit i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   cfg_err    out  sticky configuration error, cleared by an accepted start
// ---------------------------------------------------------------------------
module delay_sched #(
  parameter int NUM_UNITS     = 4,
  parameter int ADDRESS_WIDTH = 6,
  parameter int LEN_W         = 16,
  localparam int CFG_AW       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_we,
  input  logic [CFG_AW-1:0]                cfg_addr,
  input  logic [ADDRESS_WIDTH-1:0]         cfg_amount,
  input  logic                             start,
  input  logic [LEN_W-1:0]                 len,
  output logic                             busy,
  output logic                             done,
  output logic                             run,
  output logic                             in_valid,
  output logic                             out_valid,
  output logic [NUM_UNITS*ADDRESS_WIDTH-1:0] amount,
  output logic                             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CFG_AW:0] UNIT_COUNT = (CFG_AW + 1)'(NUM_UNITS);

`ifdef DELAY_SCHED_CLAMP_EN
  localparam logic [ADDRESS_WIDTH-1:0] AMT_LIMIT =
    ADDRESS_WIDTH'((1 << ADDRESS_WIDTH) - 2);
`endif

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] shadow [NUM_UNITS];
  logic [ADDRESS_WIDTH-1:0] shadow_max;
  logic [ADDRESS_WIDTH-1:0] m_q;
  logic [ADDRESS_WIDTH-1:0] prime_cnt;
  logic                     primed;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         feed_cnt;
  logic [LEN_W-1:0]         out_cnt;

  logic                     addr_ok;
  logic                     amt_bad;
  logic [ADDRESS_WIDTH-1:0] wr_amount;
  logic                     start_ok;
  logic [LEN_W-1:0]         feed_next;
  logic [LEN_W-1:0]         out_next;
  logic                     feed_last;
  logic                     out_last;
  logic                     prime_hit;

  // Decode a configuration write. The all-ones amount is the only value
  // above the legal limit, so a reduction AND detects it.
  always_comb begin
    addr_ok = ({1'b0, cfg_addr} < UNIT_COUNT);
`ifdef DELAY_SCHED_CLAMP_EN
    amt_bad   = 1'b0;
    wr_amount = (&cfg_amount) ? AMT_LIMIT : cfg_amount;
`else
    amt_bad   = &cfg_amount;
    wr_amount = cfg_amount;
`endif
  end

  assign start_ok = (state == S_IDLE) && start;

  // The maximum shadow amount becomes the priming depth of the next stream.
  always_comb begin
    shadow_max = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (shadow[i] > shadow_max) begin
        shadow_max = shadow[i];
      end
    end
  end

  // Counter look-ahead. The counters stop at len_q, so they never wrap,
  // even for the largest len.
  always_comb begin
    feed_next = feed_cnt + 1'b1;
    out_next  = out_cnt + 1'b1;
    feed_last = (state == S_RUN) && (feed_next == len_q);
    out_last  = out_valid && (out_next == len_q);
    prime_hit = !primed && (prime_cnt == m_q);
  end

  // Shadow registers accept writes in every state. A write at the same
  // edge as start lands here, but the active copy still gets the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        shadow[i] <= '0;
      end
    end else if (cfg_we && addr_ok) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (cfg_addr == CFG_AW'(i)) begin
          shadow[i] <= wr_amount;
        end
      end
    end
  end

  // Sticky error flag. A new error at the same edge as a start wins, so
  // that error is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err <= 1'b0;
    end else if (cfg_we && (!addr_ok || amt_bad)) begin
      cfg_err <= 1'b1;
    end else if (start_ok) begin
      cfg_err <= 1'b0;
    end
  end

  // Stream sequencer. It runs three counters side by side:
  //   feed  - counts in_valid cycles in RUN.
  //   prime - waits M+1 cycles from entry to RUN before out_valid opens.
  //   out   - counts out_valid cycles. When it reaches len the stream ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      run       <= 1'b0;
      in_valid  <= 1'b0;
      out_valid <= 1'b0;
      amount    <= '0;
      m_q       <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
      len_q     <= '0;
      feed_cnt  <= '0;
      out_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
              amount[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= shadow[i];
            end
            m_q       <= shadow_max;
            len_q     <= len;
            feed_cnt  <= '0;
            out_cnt   <= '0;
            prime_cnt <= '0;
            primed    <= 1'b0;
            busy      <= 1'b1;
            if (len == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              run      <= 1'b1;
              in_valid <= 1'b1;
              state    <= S_RUN;
            end
          end
        end

        S_RUN, S_DRAIN: begin
          if (state == S_RUN) begin
            feed_cnt <= feed_next;
            if (feed_last) begin
              in_valid <= 1'b0;
            end
          end

          if (prime_hit) begin
            primed    <= 1'b1;
            out_valid <= 1'b1;
          end else if (!primed) begin
            prime_cnt <= prime_cnt + 1'b1;
          end

          if (out_valid) begin
            out_cnt <= out_next;
          end

          if (out_last) begin
            out_valid <= 1'b0;
            in_valid  <= 1'b0;
            run       <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (feed_last) begin
            state <= S_DRAIN;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// ---------------------------------------------------------------------------
// tb_delay_sched
//
// Self-checking bench for delay_sched (NUM_UNITS=4, ADDRESS_WIDTH=6,
// LEN_W=16). A behavioural model runs next to the DUT. It describes each
// stream as a set of timing windows derived from its start edge, M and len,
// and predicts every output on every cycle. A table of stream vectors and a
// few hand-written sequences check window edges against hand-derived values.
// The bench honours DELAY_SCHED_CLAMP_EN when it sets its expectations.
// ---------------------------------------------------------------------------
module tb_delay_sched;

  localparam int NU      = 4;
  localparam int AW      = 6;
  localparam int LW      = 16;
  localparam int AMT_TOP = (1 << AW) - 2;

`ifdef DELAY_SCHED_CLAMP_EN
  localparam int BIG_AMT = 62;
  localparam int ERR_63  = 0;
`else
  localparam int BIG_AMT = 63;
  localparam int ERR_63  = 1;
`endif

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             cfg_we     = 1'b0;
  logic [1:0]       cfg_addr   = '0;
  logic [AW-1:0]    cfg_amount = '0;
  logic             start      = 1'b0;
  logic [LW-1:0]    len        = '0;
  logic             busy, done, run, in_valid, out_valid, cfg_err;
  logic [NU*AW-1:0] amount;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  delay_sched #(
    .NUM_UNITS    (NU),
    .ADDRESS_WIDTH(AW),
    .LEN_W        (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_amount(cfg_amount),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .run       (run),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .amount    (amount),
    .cfg_err   (cfg_err)
  );

  // Behavioural model: the current stream is described by its start edge,
  // its M and len, and its done edge.
  logic [AW-1:0] m_shadow [NU];
  logic [AW-1:0] m_active [NU];
  bit            m_err;
  bit            m_live;
  longint        m_t, m_m, m_l, m_end;
  longint        edge_no = 0;

  function automatic void model_reset();
    foreach (m_shadow[i]) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_err  = 1'b0;
    m_live = 1'b0;
    m_t    = 0;
    m_m    = 0;
    m_l    = 0;
    m_end  = 0;
  endfunction

  // A start is taken two edges after done at the earliest.
  function automatic bit model_idle();
    return !m_live || (edge_no >= m_end + 2);
  endfunction

  function automatic void model_step();
    longint mx;
    edge_no++;
    if (start && model_idle()) begin
      mx = 0;
      foreach (m_shadow[i]) begin
        m_active[i] = m_shadow[i];
        if (longint'(m_shadow[i]) > mx) mx = longint'(m_shadow[i]);
      end
      m_m    = mx;
      m_l    = longint'(len);
      m_t    = edge_no;
      m_end  = (len == '0) ? edge_no : edge_no + 1 + m_m + m_l;
      m_live = 1'b1;
      m_err  = 1'b0;
    end
    if (cfg_we) begin
      if (int'(cfg_addr) >= NU) begin
        m_err = 1'b1;
      end else if (int'(cfg_amount) > AMT_TOP) begin
`ifdef DELAY_SCHED_CLAMP_EN
        m_shadow[cfg_addr] = AW'(AMT_TOP);
`else
        m_shadow[cfg_addr] = cfg_amount;
        m_err = 1'b1;
`endif
      end else begin
        m_shadow[cfg_addr] = cfg_amount;
      end
    end
  endfunction

  function automatic logic [NU*AW+5:0] model_expect();
    longint           e;
    bit               act, eb, ed, er, ei, eo;
    logic [NU*AW-1:0] amt;
    e   = edge_no;
    act = m_live && (e >= m_t) && (e <= m_end);
    eb  = act;
    ed  = m_live && (e == m_end);
    er  = act && (m_l > 0) && (e < m_end);
    ei  = act && (m_l > 0) && (e <= m_t + m_l - 1);
    eo  = act && (m_l > 0) && (e >= m_t + 1 + m_m) && (e <= m_t + m_m + m_l);
    foreach (m_active[i]) amt[i*AW +: AW] = m_active[i];
    return {eb, ed, er, ei, eo, m_err, amt};
  endfunction

  task automatic check_output();
    logic [NU*AW+5:0] got, exp;
    got = {busy, done, run, in_valid, out_valid, cfg_err, amount};
    exp = model_expect();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL cycle edge=%0d got=%h exp=%h", edge_no, got, exp);
    end
  endtask

  task automatic check_val(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // The model samples the inputs at each rising edge, and every output is
  // checked 1 time unit later.
  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) model_step();
    else     edge_no++;
    #1;
    check_output();
  end

  typedef struct {
    int               first_in;
    int               n_in;
    int               first_out;
    int               n_out;
    int               done_cyc;
    int               n_busy;
    int               n_done;
    logic [NU*AW-1:0] amt_at_done;
    bit               post_busy;
    bit               timed_out;
  } result_t;

  typedef struct {
    logic [NU*AW-1:0] amts;
    int               l;
    int               first_in;
    int               n_in;
    int               first_out;
    int               n_out;
    int               done_cyc;
  } vec_t;

  task automatic program_amounts(input logic [NU*AW-1:0] a);
    for (int i = 0; i < NU; i++) begin
      @(negedge clk);
      cfg_we     = 1'b1;
      cfg_addr   = 2'(i);
      cfg_amount = a[i*AW +: AW];
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Starts a stream and measures its windows in cycles, where cycle 1 is the
  // first cycle after the start edge. inj_kind 1 writes unit 1 = 7 and
  // inj_kind 2 pulses start. Both act at cycle inj_cyc. start_at_done
  // pulses start in the done cycle.
  task automatic run_stream(input int l, input int inj_kind, input int inj_cyc,
                            input bit start_at_done, output result_t r);
    bit seen_done;
    seen_done = 1'b0;
    r = '{default: 0};
    @(negedge clk);
    start  = 1'b1;
    len    = LW'(l);
    cfg_we = 1'b0;
    for (int c = 1; c <= 400 && !seen_done; c++) begin
      @(posedge clk);
      #1;
      if (in_valid) begin
        if (r.n_in == 0) r.first_in = c;
        r.n_in++;
      end
      if (out_valid) begin
        if (r.n_out == 0) r.first_out = c;
        r.n_out++;
      end
      if (busy) r.n_busy++;
      if (done) begin
        r.n_done++;
        r.done_cyc    = c;
        r.amt_at_done = amount;
        seen_done     = 1'b1;
      end
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
      if (inj_kind == 1 && c == inj_cyc) begin
        cfg_we     = 1'b1;
        cfg_addr   = 2'd1;
        cfg_amount = 6'd7;
      end
      if (inj_kind == 2 && c == inj_cyc) begin
        start = 1'b1;
        len   = 16'd9;
      end
      if (seen_done && start_at_done) begin
        start = 1'b1;
        len   = 16'd9;
      end
    end
    r.timed_out = !seen_done;
    @(posedge clk);
    #1;
    r.post_busy = busy;
    r.n_done    = r.n_done + int'(done);
    start       = 1'b0;
    cfg_we      = 1'b0;
  endtask

  task automatic check_stream(input string tag, input result_t r, input int fi,
                              input int ni, input int fo, input int no, input int dc,
                              input logic [NU*AW-1:0] amt);
    check_val({tag, ".timeout"},   r.timed_out,   0);
    check_val({tag, ".first_in"},  r.first_in,    fi);
    check_val({tag, ".n_in"},      r.n_in,        ni);
    check_val({tag, ".first_out"}, r.first_out,   fo);
    check_val({tag, ".n_out"},     r.n_out,       no);
    check_val({tag, ".done_cyc"},  r.done_cyc,    dc);
    check_val({tag, ".n_busy"},    r.n_busy,      dc);
    check_val({tag, ".n_done"},    r.n_done,      1);
    check_val({tag, ".amount"},    r.amt_at_done, amt);
    check_val({tag, ".post_busy"}, r.post_busy,   0);
  endtask

  task automatic apply_stimulus(input vec_t v, output result_t r);
    program_amounts(v.amts);
    run_stream(v.l, 0, 0, 1'b0, r);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t    tbl [7];
    result_t r;

    model_reset();
    // Amounts are written {unit3, unit2, unit1, unit0}.
    tbl[0] = '{{6'd2, 6'd1, 6'd3, 6'd0},  5, 1,  5,  5,  5, 10};
    tbl[1] = '{{6'd0, 6'd0, 6'd0, 6'd0},  1, 1,  1,  2,  1,  3};
    tbl[2] = '{{6'd5, 6'd0, 6'd2, 6'd10}, 3, 1,  3, 12,  3, 15};
    tbl[3] = '{{6'd0, 6'd0, 6'd0, 6'd62}, 4, 1,  4, 64,  4, 68};
    tbl[4] = '{{6'd1, 6'd1, 6'd1, 6'd1},  8, 1,  8,  3,  8, 11};
    tbl[5] = '{{6'd4, 6'd0, 6'd0, 6'd0},  0, 0,  0,  0,  0,  1};
    tbl[6] = '{{6'd0, 6'd9, 6'd0, 6'd0}, 20, 1, 20, 11, 20, 31};

    #1 rst = 1'b0;
    #1;
    check_val("reset_state", {busy, done, run, in_valid, out_valid, cfg_err, amount}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      apply_stimulus(tbl[k], r);
      check_stream($sformatf("vec%0d", k), r, tbl[k].first_in, tbl[k].n_in,
                   tbl[k].first_out, tbl[k].n_out, tbl[k].done_cyc, tbl[k].amts);
    end

    // A shadow write in mid-stream only takes effect at the next start.
    program_amounts({6'd2, 6'd1, 6'd3, 6'd0});
    run_stream(5, 1, 2, 1'b0, r);
    check_stream("midcfg", r, 1, 5, 5, 5, 10, {6'd2, 6'd1, 6'd3, 6'd0});
    run_stream(2, 0, 0, 1'b0, r);
    check_stream("midcfg_next", r, 1, 2, 9, 2, 11, {6'd2, 6'd1, 6'd7, 6'd0});

    // Reset asserted in DRAIN clears all outputs at once and zeroes shadows.
    @(negedge clk);
    start = 1'b1;
    len   = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("drain_state", {busy, run, in_valid, out_valid, done}, 5'b11000);
    #1 rst = 1'b0;
    #1;
    check_val("mid_reset", {busy, done, run, in_valid, out_valid, cfg_err, amount}, 0);
    @(negedge clk);
    rst = 1'b1;
    run_stream(3, 0, 0, 1'b0, r);
    check_stream("post_reset", r, 1, 3, 2, 3, 5, '0);

    // Writing the all-ones amount tests clamping and the sticky error.
    @(negedge clk);
    cfg_we     = 1'b1;
    cfg_addr   = 2'd2;
    cfg_amount = 6'd63;
    @(negedge clk);
    cfg_we = 1'b0;
    check_val("err_after_63", cfg_err, ERR_63);
    repeat (3) @(negedge clk);
    check_val("err_sticky", cfg_err, ERR_63);
    run_stream(1, 0, 0, 1'b0, r);
    check_stream("amt63", r, 1, 1, 2 + BIG_AMT, 1, 3 + BIG_AMT, longint'(BIG_AMT) << 12);
    check_val("err_cleared", cfg_err, 0);

    // A start pulsed in RUN and another in the done cycle are both ignored.
    // The start in the first idle cycle is accepted.
    program_amounts({6'd2, 6'd0, 6'd0, 6'd1});
    run_stream(4, 2, 2, 1'b1, r);
    check_stream("ignored_start", r, 1, 4, 4, 4, 8, {6'd2, 6'd0, 6'd0, 6'd1});
    run_stream(3, 0, 0, 1'b0, r);
    check_stream("first_idle_start", r, 1, 3, 4, 3, 7, {6'd2, 6'd0, 6'd0, 6'd1});

    // Random traffic, checked every cycle against the model.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_addr   = 2'($urandom_range(0, 3));
      cfg_amount = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 12));
      start      = ($urandom_range(0, 5) == 0);
      len        = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 10));
    end
    @(negedge clk);
    cfg_we = 1'b0;
    start  = 1'b0;
    begin
      int w;
      w = 0;
      while (busy && w < 500) begin
        @(negedge clk);
        w++;
      end
      check_val("final_idle", busy, 0);
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
